// File: rtl/cpu_regs_pkg.sv
// rtl/cpu_regs_pkg.sv - shared types and constants for the cpu_registers bank
package cpu_regs_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    localparam data_t REG_RST_VAL = '0;

    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_O = 2;

endpackage

// File: rtl/cpu_registers_en_reg.sv
// rtl/cpu_registers_en_reg.sv - WIDTH-bit load-enable register, sync active-low reset
module en_reg
    import cpu_regs_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= WIDTH'(REG_RST_VAL);
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_registers.sv
// rtl/cpu_registers.sv - A/B/OUT register bank on shared C_in bus; optional CPU_REGS_WRITTEN_FLAGS_EN
module cpu_registers
    import cpu_regs_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] C_in,
    input  logic             write_a,
    input  logic             write_b,
    input  logic             write_o,
    output logic [WIDTH-1:0] A_reg,
    output logic [WIDTH-1:0] B_reg,
    output logic [WIDTH-1:0] OUT_reg
`ifdef CPU_REGS_WRITTEN_FLAGS_EN
    ,
    output logic [2:0]       written
`endif
);

    en_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk  (clk),
        .rstn (rstn),
        .en   (write_a),
        .d    (C_in),
        .q    (A_reg)
    );

    en_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk  (clk),
        .rstn (rstn),
        .en   (write_b),
        .d    (C_in),
        .q    (B_reg)
    );

    en_reg #(.WIDTH(WIDTH)) u_reg_o (
        .clk  (clk),
        .rstn (rstn),
        .en   (write_o),
        .d    (C_in),
        .q    (OUT_reg)
    );

`ifdef CPU_REGS_WRITTEN_FLAGS_EN
    // Sticky per-register flags; reset wins over any enable on the same edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            written <= 3'b000;
        end else begin
            if (write_a) written[IDX_A] <= 1'b1;
            if (write_b) written[IDX_B] <= 1'b1;
            if (write_o) written[IDX_O] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_registers.sv
// tb/tb_cpu_registers.sv - self-checking bench for cpu_registers against a behavioural model
module tb_cpu_registers;

    localparam int W = 8;

    logic         clk;
    logic         rstn;
    logic [W-1:0] C_in;
    logic         write_a;
    logic         write_b;
    logic         write_o;
    logic [W-1:0] A_reg;
    logic [W-1:0] B_reg;
    logic [W-1:0] OUT_reg;
`ifdef CPU_REGS_WRITTEN_FLAGS_EN
    logic [2:0]   written;
`endif

    int checks_run;
    int checks_failed;

    logic [W-1:0] model_val [3];
    bit           model_flag [3];

    cpu_registers #(.WIDTH(W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .C_in    (C_in),
        .write_a (write_a),
        .write_b (write_b),
        .write_o (write_o),
        .A_reg   (A_reg),
        .B_reg   (B_reg),
        .OUT_reg (OUT_reg)
`ifdef CPU_REGS_WRITTEN_FLAGS_EN
        ,
        .written (written)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_run++;
        if (got !== exp) begin
            checks_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " A"},   32'(A_reg),   32'(model_val[0]));
        check({tag, " B"},   32'(B_reg),   32'(model_val[1]));
        check({tag, " OUT"}, 32'(OUT_reg), 32'(model_val[2]));
`ifdef CPU_REGS_WRITTEN_FLAGS_EN
        check({tag, " written"}, 32'(written),
              32'({model_flag[2], model_flag[1], model_flag[0]}));
`endif
    endtask

    // Drive one edge's worth of inputs, advance the model on the edge, compare at the falling edge.
    task automatic step(input bit rst_n, input bit wa, input bit wb, input bit wo,
                        input logic [W-1:0] c, input string tag);
        bit en [3];
        rstn    = rst_n;
        write_a = wa;
        write_b = wb;
        write_o = wo;
        C_in    = c;
        en[0] = wa; en[1] = wb; en[2] = wo;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                model_val[i]  = '0;
                model_flag[i] = 1'b0;
            end else if (en[i]) begin
                model_val[i]  = c;
                model_flag[i] = 1'b1;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        checks_run    = 0;
        checks_failed = 0;
        for (int i = 0; i < 3; i++) begin
            model_val[i]  = 'x;
            model_flag[i] = 1'b0;
        end

        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h96, "reset1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h96, "reset2");
        check("reset A literal", 32'(A_reg), 32'h0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h96, "load_a");
        check("load_a A literal", 32'(A_reg), 32'h96);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h3c, "load_b");
        check("load_b B literal", 32'(B_reg), 32'h3c);

        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hff, "load_all");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "hold");
        check("hold OUT literal", 32'(OUT_reg), 32'hff);

        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, "reset_dominates");

        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h55, "write_out_only");
`ifdef CPU_REGS_WRITTEN_FLAGS_EN
        check("flags literal", 32'(written), 32'h4);
`endif
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h12, "reload1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h34, "reload2");

        // Inputs changed between edges must not reach the outputs.
        rstn = 1'b0; write_a = 1'b1; write_b = 1'b1; write_o = 1'b1; C_in = 8'hAA;
        #2;
        check_all("mid_cycle");
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h5a, "after_mid_cycle");

        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "reset_again");
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hc3, "no_recovery_cycle");

        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 W'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_run, checks_failed);
        $finish;
    end

endmodule
